mat_result_writer: RTL and testbench
====================================

Name: mat_result_writer

Overview:
- Write-side counterpart of the operand-reading matrix FSM.
- Accepts result elements from the ALU/compute stage as a valid/ready stream in row-major order.
- Writes each element to result memory at RES_ADDR plus an offset. The offset is row-major, or column-major when a transpose is requested.
- After the last element it writes 0 to the op-code word, which hands the op slot back to the reader FSM, then pulses done.

Parameters:
- ADDR_WIDTH, 12, memory address width
- DATA_WIDTH, 32, element width (fp32 bit pattern, passed through untouched)
- DIM_WIDTH, 6, matrix dimension width (max 63)
- RES_BASE, 999, base address of the result matrix
- OP_BASE, 999, address of the op-code word cleared on completion

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin an operation; sampled only in IDLE
- dim1  input  DIM_WIDTH  rows of the incoming result; latched on start
- dim2  input  DIM_WIDTH  columns of the incoming result; latched on start
- transpose  input  1  1 = store column-major (MAT_TRAS); latched on start
- in_valid  input  1  result element present
- in_data  input  DATA_WIDTH  result element
- in_ready  output  1  element accepted when in_valid && in_ready
- mem_busy  input  1  memory cannot accept a write this cycle
- mem_addr  output  ADDR_WIDTH  write address (registered)
- mem_data  output  DATA_WIDTH  write data (registered)
- write  output  1  write strobe (registered); held until accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- elem_count  output  2*DIM_WIDTH  number of elements accepted so far

Behaviour:
- Interface decisions: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset values: write=0, mem_addr=0, mem_data=0, in_ready=0, busy=0, done=0, elem_count=0, state=IDLE.
- Reset asserted mid-operation: any pending write is dropped, all counters clear, and the block returns to IDLE the next cycle.
- Write acceptance: a write is accepted on a clock edge where write=1 and mem_busy=0.
- States:
  - IDLE. When start=1: latch dim1, dim2 and transpose; clear row/column/offset counters; go to STREAM. If dim1==0 or dim2==0, go directly to CLEAR_OP instead.
  - STREAM. Output register behaviour:
    - in_ready = (elem_count < N) && (!write || !mem_busy), where N = dim1*dim2.
    - On a transfer: mem_data <= in_data, mem_addr <= RES_BASE + offset, write <= 1. The write appears on the cycle after the transfer, so latency is 1.
    - With no transfer: write <= 0 if the pending write was accepted; otherwise all three outputs hold.
    - Back-to-back transfers sustain 1 element per cycle when mem_busy=0.
    - Exit to CLEAR_OP once elem_count==N and the final write has been accepted.
  - CLEAR_OP. Drive mem_addr=OP_BASE, mem_data=0, write=1. Hold until accepted, then go to DONE.
  - DONE. done=1 for exactly one cycle, write=0, then go to IDLE.
- Offset generation (no multiplier). The row counter r runs 0..dim1-1 and the column counter c runs 0..dim2-1; the input always arrives row-major.
  - transpose=0: offset increments by 1 per element.
  - transpose=1: offset += dim1 per element. When c wraps, offset = r+1, giving offset = c*dim1 + r.
  - RES_BASE+offset is computed modulo 2^ADDR_WIDTH and wraps silently. The maximum N is 3969, which fits in 12 bits.
- Element limit: in_ready stays 0 once N elements are accepted, so extra input is never consumed.
- Start handling: start is ignored outside IDLE. A start in the same cycle as reset is ignored.
- Stall behaviour: in_valid may drop between elements, and the block then simply waits. mem_busy may stay high indefinitely; outputs stay stable throughout.

Test Plan:
- Row-major write: dim1=2, dim2=3, transpose=0, data 0xA0..0xA5, mem_busy=0. Required: writes to 999..1004 in order on consecutive cycles, then a write of 0 to 999, then a done pulse; total 9 cycles from start.
- Transposed write: dim1=2, dim2=3, transpose=1, data d0..d5. Required: addresses 999, 1001, 1003, 1000, 1002, 1004.
- Backpressure: mem_busy=1 for 3 cycles while the second write is pending. Required: that write is held with stable addr/data; in_ready=0 during the stall; no element lost or duplicated; 6 data writes total.
- Zero size: dim1=0, dim2=5, start. Required: no data writes, one write of 0 to 999, done, elem_count=0.
- Reset mid-stream: reset after 2 of 6 elements. Required: write=0, busy=0 and elem_count=0 the next cycle. A following start with dim 1x1 writes only to 999, then clears the op word.
- Start while busy and excess input: start pulsed during STREAM is ignored; in_valid held high after N elements gets in_ready=0, with no extra writes.

Source files
------------

// File: rtl/mat_result_writer.sv
// Result-side matrix writer: streams row-major result elements into result memory
// (optionally transposed), then clears the op-code word and pulses done.
module mat_result_writer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 6,
  parameter int unsigned RES_BASE   = 999,
  parameter int unsigned OP_BASE    = 999
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   dim1,
  input  logic [DIM_WIDTH-1:0]   dim2,
  input  logic                   transpose,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  input  logic                   mem_busy,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_data,
  output logic                   write,
  output logic                   busy,
  output logic                   done,
  output logic [2*DIM_WIDTH-1:0] elem_count
);

  localparam int unsigned CNT_W = 2 * DIM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_CLEAR_OP,
    S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [DIM_WIDTH-1:0]  r_dim1, w_dim1;
  logic [DIM_WIDTH-1:0]  r_dim2, w_dim2;
  logic                  r_tras, w_tras;
  logic [DIM_WIDTH-1:0]  r_row, w_row;
  logic [DIM_WIDTH-1:0]  r_col, w_col;
  logic [CNT_W-1:0]      r_off, w_off;
  logic                  r_all_in, w_all_in;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_write, w_write;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  logic w_in_ready;
  logic w_xfer;
  logic w_acc;
  logic w_row_last;
  logic w_col_last;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dim1   <= '0;
      r_dim2   <= '0;
      r_tras   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_off    <= '0;
      r_all_in <= 1'b0;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_dim1   <= w_dim1;
      r_dim2   <= w_dim2;
      r_tras   <= w_tras;
      r_row    <= w_row;
      r_col    <= w_col;
      r_off    <= w_off;
      r_all_in <= w_all_in;
      r_cnt    <= w_cnt;
      r_write  <= w_write;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Next-state, handshake and offset generation
  always_comb begin
    w_state    = r_state;
    w_dim1     = r_dim1;
    w_dim2     = r_dim2;
    w_tras     = r_tras;
    w_row      = r_row;
    w_col      = r_col;
    w_off      = r_off;
    w_all_in   = r_all_in;
    w_cnt      = r_cnt;
    w_write    = r_write;
    w_addr     = r_addr;
    w_data     = r_data;
    w_done     = 1'b0;
    w_in_ready = (r_state == S_STREAM) && !r_all_in && (!r_write || !mem_busy);
    w_xfer     = w_in_ready && in_valid;
    w_acc      = r_write && !mem_busy;
    w_row_last = (r_row == r_dim1 - DIM_WIDTH'(1));
    w_col_last = (r_col == r_dim2 - DIM_WIDTH'(1));

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dim1   = dim1;
          w_dim2   = dim2;
          w_tras   = transpose;
          w_row    = '0;
          w_col    = '0;
          w_off    = '0;
          w_all_in = 1'b0;
          w_cnt    = '0;
          if (dim1 == '0 || dim2 == '0) begin
            w_state = S_CLEAR_OP;
            w_write = 1'b1;
            w_addr  = ADDR_WIDTH'(OP_BASE);
            w_data  = '0;
          end else begin
            w_state = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (w_xfer) begin
          w_data  = in_data;
          w_addr  = ADDR_WIDTH'(RES_BASE) + ADDR_WIDTH'(r_off);
          w_write = 1'b1;
          w_cnt   = r_cnt + CNT_W'(1);
          // Transposed: step by dim1 along a row, restart at the next row index on wrap
          if (w_col_last) begin
            w_col = '0;
            w_row = r_row + DIM_WIDTH'(1);
            w_off = r_tras ? CNT_W'(r_row) + CNT_W'(1) : r_off + CNT_W'(1);
            if (w_row_last) begin
              w_all_in = 1'b1;
            end
          end else begin
            w_col = r_col + DIM_WIDTH'(1);
            w_off = r_tras ? r_off + CNT_W'(r_dim1) : r_off + CNT_W'(1);
          end
        end else if (w_acc) begin
          w_write = 1'b0;
        end
        if (r_all_in && (!r_write || w_acc)) begin
          w_state = S_CLEAR_OP;
          w_write = 1'b1;
          w_addr  = ADDR_WIDTH'(OP_BASE);
          w_data  = '0;
        end
      end

      S_CLEAR_OP: begin
        if (!mem_busy) begin
          w_state = S_DONE;
          w_write = 1'b0;
          w_done  = 1'b1;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  assign in_ready   = w_in_ready;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign write      = r_write;
  assign busy       = r_busy;
  assign done       = r_done;
  assign elem_count = r_cnt;

endmodule

// File: tb/tb_mat_result_writer.sv
// Randomized self-checking bench for mat_result_writer: expected write sequences are
// built from matrix coordinates and compared against writes the memory accepts.
module tb_mat_result_writer;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned DMW = 6;
  localparam int unsigned RB  = 999;
  localparam int unsigned OB  = 999;

  logic             clock;
  logic             reset;
  logic             start;
  logic [DMW-1:0]   dim1;
  logic [DMW-1:0]   dim2;
  logic             transpose;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             mem_busy;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_data;
  logic             write;
  logic             busy;
  logic             done;
  logic [2*DMW-1:0] elem_count;

  int n_checks = 0;
  int n_fail   = 0;

  mat_result_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(DMW), .RES_BASE(RB), .OP_BASE(OB)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .dim1(dim1), .dim2(dim2),
    .transpose(transpose), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_busy(mem_busy), .mem_addr(mem_addr), .mem_data(mem_data), .write(write),
    .busy(busy), .done(done), .elem_count(elem_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete operation; expected writes derive from (row, col) coordinates of each element
  task automatic run_op(input int d1, input int d2, input bit tr, input int bpct,
                        input int vpct, input bit stall_mode, input bit glitch, input bit exact);
    int unsigned exp_a[$];
    int unsigned exp_d[$];
    int unsigned elems[$];
    int n, sent, nacc, ndone, busy_cyc, stall_left, budget;
    bit finished, prev_stall;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    n = d1 * d2;
    for (int i = 0; i < n; i++) begin
      int unsigned v;
      int r, c, off;
      v = exact ? 32'hA0 + 32'(i) : $urandom;
      elems.push_back(v);
      r = i / d2;
      c = i % d2;
      off = tr ? c * d1 + r : i;
      exp_a.push_back((RB + 32'(off)) % (1 << AW));
      exp_d.push_back(v);
    end
    exp_a.push_back(OB);
    exp_d.push_back(0);

    @(negedge clock);
    start = 1'b1; dim1 = DMW'(d1); dim2 = DMW'(d2); transpose = tr;
    in_valid = 1'b0; mem_busy = 1'b0;
    sent = 0; nacc = 0; ndone = 0; busy_cyc = 0; stall_left = 3;
    finished = 1'b0; prev_stall = 1'b0; p_addr = '0; p_data = '0;
    budget = 20 * n + 60;
    @(negedge clock);
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      start = glitch && (cyc == 3);
      if (glitch && cyc == 3) begin
        dim1 = 6'd5; dim2 = 6'd5;
      end
      if (stall_mode && write && nacc == 1 && stall_left > 0) begin
        mem_busy = 1'b1;
        stall_left--;
      end else begin
        mem_busy = ($urandom_range(99, 0) < 32'(bpct));
      end
      in_valid = (sent < n) ? ($urandom_range(99, 0) < 32'(vpct)) : 1'b1;
      in_data  = (sent < n) ? elems[sent] : $urandom;
      #1;
      if (busy) busy_cyc++;
      chk("elem_count", 64'(elem_count), 64'(sent));
      if (prev_stall) begin
        chk("stall_write", 64'(write), 64'd1);
        chk("stall_addr", 64'(mem_addr), 64'(p_addr));
        chk("stall_data", 64'(mem_data), 64'(p_data));
      end
      if (sent == n) chk("excess_ready", 64'(in_ready), 64'd0);
      if (write && mem_busy) chk("stall_ready", 64'(in_ready), 64'd0);
      if (write && !mem_busy) begin
        if (nacc < exp_a.size()) begin
          chk("wr_addr", 64'(mem_addr), 64'(exp_a[nacc]));
          chk("wr_data", 64'(mem_data), 64'(exp_d[nacc]));
        end else begin
          chk("extra_write", 64'(nacc), 64'(exp_a.size() - 1));
        end
        nacc++;
      end
      if (in_valid && in_ready && sent < n) sent++;
      if (done) begin
        ndone++;
        finished = 1'b1;
      end
      prev_stall = write && mem_busy;
      p_addr = mem_addr;
      p_data = mem_data;
      @(negedge clock);
    end
    start = 1'b0;
    in_valid = 1'b0;
    mem_busy = 1'b0;
    chk("op_finished", 64'(finished), 64'd1);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("write_count", 64'(nacc), 64'(exp_a.size()));
    chk("final_count", 64'(elem_count), 64'(n));
    if (exact) chk("busy_cycles", 64'(busy_cyc), 64'd9);
    if (stall_mode) chk("stall_applied", 64'(stall_left), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dim1 = '0; dim2 = '0; transpose = 1'b0;
    in_valid = 1'b0; in_data = '0; mem_busy = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(elem_count), 64'd0);
    reset = 1'b0;

    run_op(2, 3, 1'b0, 0, 100, 1'b0, 1'b0, 1'b1);
    run_op(2, 3, 1'b1, 0, 100, 1'b0, 1'b0, 1'b0);
    run_op(2, 3, 1'b0, 0, 100, 1'b1, 1'b0, 1'b0);
    run_op(0, 5, 1'b0, 0, 100, 1'b0, 1'b0, 1'b0);
    run_op(2, 3, 1'b0, 0, 100, 1'b0, 1'b1, 1'b0);

    // Reset after two accepted elements, with a simultaneous start that must be ignored
    @(negedge clock);
    start = 1'b1; dim1 = 6'd2; dim2 = 6'd3; transpose = 1'b0;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    @(negedge clock);
    in_data = 32'h22;
    @(negedge clock);
    chk("pre_rst_count", 64'(elem_count), 64'd2);
    reset = 1'b1; start = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    chk("mid_rst_write", 64'(write), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(elem_count), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("start_with_reset", 64'(busy), 64'd0);
    run_op(1, 1, 1'b0, 0, 100, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_op(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 1'($urandom),
             30, 70, 1'b0, 1'b0, 1'b0);
    end
    run_op(63, 63, 1'b1, 10, 90, 1'b0, 1'b0, 1'b0);
    run_op(63, 63, 1'b0, 10, 90, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
